// File: rtl/kiwi_pmu_pkg.sv
// Kiwi top-down PMU shared types.
// FSM states, read selects and width helper.
package kiwi_pmu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } pmu_state_e;

  typedef enum logic [2:0] {
    SEL_TOTAL     = 3'd0,
    SEL_INST      = 3'd1,
    SEL_RETIRE    = 3'd2,
    SEL_BUBBLE    = 3'd3,
    SEL_BACKEND   = 3'd4,
    SEL_FRONTEND  = 3'd5,
    SEL_BAD_SPEC  = 3'd6,
    SEL_FLUSH_REC = 3'd7
  } rd_sel_e;

  localparam int NUM_CNT = 7;

  // Bits needed to hold values 0..n.
  function automatic int cnt_w_for(int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/kiwi_topdown_pmu_if.sv
// Kiwi top-down PMU read port.
// Request/select in, pipelined data out.
interface kiwi_topdown_pmu_if #(
  parameter int CNT_W = 64
);
  logic             rd_req_i;
  logic [2:0]       rd_sel_i;
  logic             rd_vld_o;
  logic [CNT_W-1:0] rd_data_o;

  modport master (
    output rd_req_i,
    output rd_sel_i,
    input  rd_vld_o,
    input  rd_data_o
  );

  modport slave (
    input  rd_req_i,
    input  rd_sel_i,
    output rd_vld_o,
    output rd_data_o
  );
endinterface

// File: rtl/kiwi_pmu_sat_cnt.sv
// Kiwi PMU saturating accumulator.
// Adds inc_i when enabled, sticks at all-ones.
module kiwi_pmu_sat_cnt #(
  parameter int CNT_W = 64,
  parameter int INC_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [INC_W-1:0] inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   sum;

  assign sum = {1'b0, cnt_q}
             + {{(CNT_W+1-INC_W){1'b0}}, inc_i};

  // Accumulate with clamp; clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= sum[CNT_W] ? MAX : sum[CNT_W-1:0];
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == MAX);

endmodule

// File: rtl/kiwi_topdown_pmu.sv
// Kiwi top-down PMU: slot accounting counters,
// halt detection and a 2-cycle read pipeline.
module kiwi_topdown_pmu
  import kiwi_pmu_pkg::*;
#(
  parameter int          DECODE_W      = 2,
  parameter int          RETIRE_W      = 2,
  parameter int          CNT_W         = 64,
  parameter int          FLUSH_PENALTY = 2,
  parameter logic [31:0] HALT_INST     = 32'h0000_006b
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [DECODE_W-1:0]   dec_vld_i,
  input  logic [DECODE_W*32-1:0] dec_inst_i,
  input  logic                  backend_stall_i,
  input  logic                  flush_i,
  input  logic [RETIRE_W-1:0]   retire_vld_i,
  kiwi_topdown_pmu_if.slave     rd,
  output logic                  halted_o,
  output logic                  ovf_o
);

  localparam int DW   = cnt_w_for(DECODE_W);
  localparam int RW   = cnt_w_for(RETIRE_W);
  localparam int MULT = DECODE_W * FLUSH_PENALTY;
  localparam int MW   = cnt_w_for(MULT);

  localparam logic [DW-1:0] TOT_INC = DW'(DECODE_W);

  pmu_state_e state_q;
  logic       halted_q;
  logic       ovf_q;
  logic       cnt_en;

  logic [DW-1:0] dec_pop;
  logic [DW-1:0] bub_inc;
  logic [DW-1:0] be_inc;
  logic [DW-1:0] fe_inc;
  logic [RW-1:0] ret_pop;
  logic          halt_hit;

  logic [CNT_W-1:0] c_total;
  logic [CNT_W-1:0] c_inst;
  logic [CNT_W-1:0] c_ret;
  logic [CNT_W-1:0] c_bub;
  logic [CNT_W-1:0] c_be;
  logic [CNT_W-1:0] c_fe_raw;
  logic [CNT_W-1:0] c_flush;
  logic [NUM_CNT-1:0] sat;

  logic [CNT_W+MW-1:0] rec_prod;
  logic [CNT_W-1:0]    flush_rec;
  logic [CNT_W-1:0]    frontend;
  logic [CNT_W-1:0]    bad_spec;
  logic [CNT_W-1:0]    sel_val;

  logic             s1_vld;
  logic [CNT_W-1:0] s1_data;
  logic             vld_q;
  logic [CNT_W-1:0] data_q;

  assign cnt_en = (state_q == ST_RUN);

  // Slot popcounts and halt-instruction match.
  always_comb begin
    dec_pop  = '0;
    ret_pop  = '0;
    halt_hit = 1'b0;
    for (int k = 0; k < DECODE_W; k++) begin
      if (dec_vld_i[k]) begin
        dec_pop = dec_pop + DW'(1);
        if (dec_inst_i[32*k +: 32] == HALT_INST)
          halt_hit = 1'b1;
      end
    end
    for (int k = 0; k < RETIRE_W; k++) begin
      if (retire_vld_i[k])
        ret_pop = ret_pop + RW'(1);
    end
  end

  assign bub_inc = TOT_INC - dec_pop;
  assign be_inc  = backend_stall_i ? dec_pop : '0;
  assign fe_inc  = backend_stall_i ? '0 : dec_pop;

  kiwi_pmu_sat_cnt #(.CNT_W(CNT_W), .INC_W(DW)) u_total (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_i),
    .en_i(cnt_en), .inc_i(TOT_INC),
    .cnt_o(c_total), .sat_o(sat[0])
  );

  kiwi_pmu_sat_cnt #(.CNT_W(CNT_W), .INC_W(DW)) u_inst (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_i),
    .en_i(cnt_en), .inc_i(dec_pop),
    .cnt_o(c_inst), .sat_o(sat[1])
  );

  kiwi_pmu_sat_cnt #(.CNT_W(CNT_W), .INC_W(RW)) u_ret (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_i),
    .en_i(cnt_en), .inc_i(ret_pop),
    .cnt_o(c_ret), .sat_o(sat[2])
  );

  kiwi_pmu_sat_cnt #(.CNT_W(CNT_W), .INC_W(DW)) u_bub (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_i),
    .en_i(cnt_en), .inc_i(bub_inc),
    .cnt_o(c_bub), .sat_o(sat[3])
  );

  kiwi_pmu_sat_cnt #(.CNT_W(CNT_W), .INC_W(DW)) u_be (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_i),
    .en_i(cnt_en), .inc_i(be_inc),
    .cnt_o(c_be), .sat_o(sat[4])
  );

  kiwi_pmu_sat_cnt #(.CNT_W(CNT_W), .INC_W(DW)) u_fe (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_i),
    .en_i(cnt_en), .inc_i(fe_inc),
    .cnt_o(c_fe_raw), .sat_o(sat[5])
  );

  kiwi_pmu_sat_cnt #(.CNT_W(CNT_W), .INC_W(1)) u_flush (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_i),
    .en_i(cnt_en), .inc_i(flush_i),
    .cnt_o(c_flush), .sat_o(sat[6])
  );

  // Widened product so any overflow can be clamped.
  assign rec_prod  = {{MW{1'b0}}, c_flush}
                   * (CNT_W+MW)'(MULT);
  assign flush_rec = |rec_prod[CNT_W+MW-1:CNT_W]
                   ? '1 : rec_prod[CNT_W-1:0];

  assign frontend = (c_fe_raw > flush_rec)
                  ? c_fe_raw - flush_rec : '0;
  assign bad_spec = (c_inst > c_ret)
                  ? c_inst - c_ret : '0;

  // Read select mux over raw and derived counts.
  always_comb begin
    sel_val = '0;
    unique case (rd_sel_e'(rd.rd_sel_i))
      SEL_TOTAL:     sel_val = c_total;
      SEL_INST:      sel_val = c_inst;
      SEL_RETIRE:    sel_val = c_ret;
      SEL_BUBBLE:    sel_val = c_bub;
      SEL_BACKEND:   sel_val = c_be;
      SEL_FRONTEND:  sel_val = frontend;
      SEL_BAD_SPEC:  sel_val = bad_spec;
      SEL_FLUSH_REC: sel_val = flush_rec;
      default:       sel_val = '0;
    endcase
  end

  // Two-stage read pipe; not touched by clr_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      s1_vld  <= rd.rd_req_i;
      s1_data <= rd.rd_req_i ? sel_val : '0;
      vld_q   <= s1_vld;
      data_q  <= s1_vld ? s1_data : '0;
    end
  end

  // Sticky overflow, raised once any counter sits at max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (clr_i) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (|sat);
    end
  end

  // Run-state FSM with registered halted flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      halted_q <= 1'b0;
    end else if (clr_i) begin
      state_q  <= ST_IDLE;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (en_i)
            state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (halt_hit) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end else if (!en_i) begin
            state_q <= ST_IDLE;
          end
        end
        ST_HALTED: begin
          state_q <= ST_HALTED;
        end
        default: begin
          state_q  <= ST_IDLE;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign halted_o     = halted_q;
  assign ovf_o        = ovf_q;
  assign rd.rd_vld_o  = vld_q;
  assign rd.rd_data_o = data_q;

endmodule

// File: tb/tb_kiwi_topdown_pmu.sv
// Directed bench for kiwi_topdown_pmu.
// Default instance plus a narrow 8-slot instance.
module tb_kiwi_topdown_pmu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en, clr, stall, flush;
  logic [1:0]  dec_vld, ret;
  logic [63:0] dec_inst;
  logic        halted, ovf;

  logic         s_en, s_clr, s_stall, s_flush;
  logic [7:0]   s_vld;
  logic [255:0] s_inst;
  logic [1:0]   s_ret;
  logic         s_halted, s_ovf;

  int n_chk = 0;
  int n_err = 0;

  kiwi_topdown_pmu_if #(.CNT_W(64)) rd ();
  kiwi_topdown_pmu_if #(.CNT_W(4))  s_rd ();

  kiwi_topdown_pmu dut (
    .clk(clk), .rst_n(rst_n),
    .en_i(en), .clr_i(clr),
    .dec_vld_i(dec_vld), .dec_inst_i(dec_inst),
    .backend_stall_i(stall), .flush_i(flush),
    .retire_vld_i(ret), .rd(rd.slave),
    .halted_o(halted), .ovf_o(ovf)
  );

  kiwi_topdown_pmu #(.DECODE_W(8), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .en_i(s_en), .clr_i(s_clr),
    .dec_vld_i(s_vld), .dec_inst_i(s_inst),
    .backend_stall_i(s_stall), .flush_i(s_flush),
    .retire_vld_i(s_ret), .rd(s_rd.slave),
    .halted_o(s_halted), .ovf_o(s_ovf)
  );

  task automatic chk(string tag,
                     logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(string tag,
                        logic [2:0] sel,
                        logic [63:0] exp);
    rd.rd_req_i = 1'b1;
    rd.rd_sel_i = sel;
    tick();
    rd.rd_req_i = 1'b0;
    tick();
    chk({tag, "_vld"}, 64'(rd.rd_vld_o), 64'd1);
    chk(tag, rd.rd_data_o, exp);
  endtask

  task automatic clear();
    en  = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // One IDLE->RUN cycle, then n counted RUN cycles.
  task automatic run(int n, logic [1:0] v, logic st,
                     logic fl, logic [1:0] r);
    en = 1'b1;
    dec_vld = '0; stall = 0; flush = 0; ret = '0;
    tick();
    for (int i = 0; i < n; i++) begin
      en = (i != n - 1);
      dec_vld = v; stall = st; flush = fl; ret = r;
      tick();
    end
    en = 1'b0;
    dec_vld = '0; stall = 0; flush = 0; ret = '0;
  endtask

  logic [3:0] s_exp [8];

  initial begin
    rst_n = 0; en = 0; clr = 0; stall = 0; flush = 0;
    dec_vld = '0; ret = '0; dec_inst = '0;
    s_en = 0; s_clr = 0; s_stall = 0; s_flush = 0;
    s_vld = '0; s_ret = '0; s_inst = '0;
    rd.rd_req_i = 0; rd.rd_sel_i = '0;
    s_rd.rd_req_i = 0; s_rd.rd_sel_i = '0;
    tick();
    tick();
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_vld", 64'(rd.rd_vld_o), 64'd0);
    chk("rst_data", rd.rd_data_o, 64'd0);
    rst_n = 1;
    tick();
    rd_chk("rst_total", 3'd0, 64'd0);

    // full frontend-bound decode with full retire
    run(10, 2'b11, 1'b0, 1'b0, 2'b11);
    rd_chk("a_total", 3'd0, 64'd20);
    rd_chk("a_inst", 3'd1, 64'd20);
    rd_chk("a_ret", 3'd2, 64'd20);
    rd_chk("a_bub", 3'd3, 64'd0);
    rd_chk("a_fe", 3'd5, 64'd20);
    rd_chk("a_bad", 3'd6, 64'd0);
    chk("a_ovf", 64'(ovf), 64'd0);

    // read in flight across clr keeps its sample
    rd.rd_req_i = 1; rd.rd_sel_i = 3'd0; clr = 1;
    tick();
    rd.rd_req_i = 0; clr = 0;
    tick();
    chk("clr_rd_vld", 64'(rd.rd_vld_o), 64'd1);
    chk("clr_rd_data", rd.rd_data_o, 64'd20);
    rd_chk("clr_total", 3'd0, 64'd0);

    // backend stall with half-empty decode
    run(4, 2'b01, 1'b1, 1'b0, 2'b00);
    rd_chk("b_be", 3'd4, 64'd4);
    rd_chk("b_bub", 3'd3, 64'd4);
    rd_chk("b_total", 3'd0, 64'd8);
    rd_chk("b_bad", 3'd6, 64'd4);
    rd_chk("b_fe", 3'd5, 64'd0);

    // flush recovery subtracts from frontend
    clear();
    run(3, 2'b00, 1'b0, 1'b1, 2'b00);
    run(10, 2'b11, 1'b0, 1'b0, 2'b00);
    rd_chk("c_rec", 3'd7, 64'd12);
    rd_chk("c_fe", 3'd5, 64'd8);
    rd_chk("c_total", 3'd0, 64'd26);
    clear();
    run(3, 2'b00, 1'b0, 1'b1, 2'b00);
    run(5, 2'b01, 1'b0, 1'b0, 2'b00);
    rd_chk("c2_rec", 3'd7, 64'd12);
    rd_chk("c2_fe", 3'd5, 64'd0);
    rd_chk("c2_bad", 3'd6, 64'd5);

    // halt instruction on slot 1 in RUN cycle 5
    clear();
    en = 1; dec_vld = '0;
    tick();
    for (int c = 1; c <= 7; c++) begin
      dec_vld  = 2'b11;
      dec_inst = (c == 5) ? {32'h0000_006b, 32'h13}
                          : {32'h13, 32'h13};
      tick();
      if (c == 4) chk("h_pre", 64'(halted), 64'd0);
      if (c == 5) chk("h_set", 64'(halted), 64'd1);
    end
    en = 0; dec_vld = '0; dec_inst = '0;
    tick();
    tick();
    chk("h_hold", 64'(halted), 64'd1);
    rd_chk("h_total", 3'd0, 64'd10);
    rd_chk("h_inst", 3'd1, 64'd10);
    clear();
    chk("h_clr", 64'(halted), 64'd0);
    tick();
    tick();
    rd_chk("h_clr_total", 3'd0, 64'd0);

    // narrow instance: saturation and streamed reads
    s_en = 1;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      s_en = (c != 2);
      s_vld = 8'hFF; s_flush = 1; s_ret = 2'b11;
      tick();
      if (c == 0) chk("s_ovf_pre", 64'(s_ovf), 64'd0);
    end
    s_en = 0; s_vld = '0; s_flush = 0; s_ret = '0;
    tick();
    tick();
    chk("s_ovf", 64'(s_ovf), 64'd1);
    s_exp = '{4'd15, 4'd15, 4'd6, 4'd0,
              4'd0, 4'd0, 4'd9, 4'd15};
    for (int k = 0; k < 11; k++) begin
      if (k >= 2 && k < 10) begin
        chk($sformatf("s_vld%0d", k - 2),
            64'(s_rd.rd_vld_o), 64'd1);
        chk($sformatf("s_sel%0d", k - 2),
            64'(s_rd.rd_data_o), 64'(s_exp[k-2]));
      end else begin
        chk($sformatf("s_idle%0d", k),
            64'(s_rd.rd_vld_o), 64'd0);
      end
      s_rd.rd_req_i = (k < 8);
      s_rd.rd_sel_i = 3'(k);
      tick();
    end

    // async reset with reads in flight
    run(2, 2'b11, 1'b0, 1'b0, 2'b11);
    rd.rd_req_i = 1; rd.rd_sel_i = 3'd0;
    tick();
    rd.rd_sel_i = 3'd1;
    tick();
    rd.rd_req_i = 0;
    chk("r_vld_pre", 64'(rd.rd_vld_o), 64'd1);
    chk("r_data_pre", rd.rd_data_o, 64'd4);
    rst_n = 0;
    #1;
    chk("r_vld_now", 64'(rd.rd_vld_o), 64'd0);
    chk("r_data_now", rd.rd_data_o, 64'd0);
    tick();
    rst_n = 1;
    tick();
    chk("r_vld_a1", 64'(rd.rd_vld_o), 64'd0);
    tick();
    chk("r_vld_a2", 64'(rd.rd_vld_o), 64'd0);
    rd_chk("r_total", 3'd0, 64'd0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
